// File: rtl/mem_access_guard_if.sv
// CPU-side native memory port and SRAM-side port of the memory access guard.
// The guard uses the slave modport; the CPU/SRAM environment uses master.
interface mem_access_guard_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    cpu_valid;
    logic                    cpu_ready;
    logic [21:0]             cpu_addr;
    logic [DATA_WIDTH-1:0]   cpu_wdata;
    logic [3:0]              cpu_wstrb;
    logic [DATA_WIDTH-1:0]   cpu_rdata;
    logic [3:0]              mem_wen;
    logic [21:0]             mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
        output cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
        input  cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_guard.sv
// Memory protection unit: loads a 5-region table from SRAM after reset, then
// checks every CPU access against it. Optional macro MPU_RELOAD_EN lets CPU
// stores into the table window update the live table.
module mem_access_guard #(
    parameter int DATA_WIDTH     = 32,
    parameter int MPU_START_ADDR = 768,
    parameter int MPU_LEN        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_inst,
    input  logic [31:0]           pc_addr,
    output logic                  inform_cpu_wait,
    output logic                  interrupt,
    output logic [31:0]           fault_pc,
    mem_access_guard_if.slave     bus
);
    localparam int          NUM_REGIONS = 5;
    localparam logic [21:0] START_W     = 22'(MPU_START_ADDR);

    typedef enum logic [1:0] {LOAD, IDLE, ACCESS, FAULT} state_t;

    state_t                  state_q;
    logic [4:0]              loadIdx_q;
    logic [21:0]             memAddr_q;
    logic [DATA_WIDTH-1:0]   memWdata_q;
    logic [31:0]             faultPc_q;
    logic                    ctlEnable_q;
    logic                    ctlDefault_q;
    logic [21:0]             regStart_q [NUM_REGIONS];
    logic [21:0]             regEnd_q   [NUM_REGIONS];
    logic [2:0]              regAttr_q  [NUM_REGIONS];

    logic                    hit;
    logic [2:0]              hitAttr;
    logic                    needOk;
    logic                    allowed;
    logic                    accept;
    logic                    deny;
    logic                    loadActive;
    logic [21:0]             memAddr_d;
    logic [DATA_WIDTH-1:0]   memWdata_d;
    logic                    tblWrEn;
    logic [3:0]              tblWrIdx;
    logic [21:0]             tblWrData;

    // Scanning from the highest region down lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        hitAttr = 3'd0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if ((regStart_q[r] <= bus.cpu_addr) && (bus.cpu_addr <= regEnd_q[r])) begin
                hit     = 1'b1;
                hitAttr = regAttr_q[r];
            end
        end
        if (is_inst)
            needOk = hitAttr[2];
        else if (bus.cpu_wstrb != 4'd0)
            needOk = hitAttr[1];
        else
            needOk = hitAttr[0];
        allowed = !ctlEnable_q || (hit ? needOk : ctlDefault_q);
    end

    assign accept     = (state_q == IDLE) && bus.cpu_valid && allowed;
    assign deny       = (state_q == IDLE) && bus.cpu_valid && !allowed;
    assign loadActive = (state_q == LOAD) && (loadIdx_q < 5'(MPU_LEN));

    always_comb begin
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        if (loadActive) begin
            memAddr_d = START_W + {17'd0, loadIdx_q};
        end else if (accept) begin
            memAddr_d  = bus.cpu_addr;
            memWdata_d = bus.cpu_wdata;
        end
    end

`ifdef MPU_RELOAD_EN
    logic        inTable;
    logic [3:0]  relIdx;
    logic [21:0] oldWord;

    assign inTable = (bus.cpu_addr >= START_W) && (bus.cpu_addr <= START_W + 22'(MPU_LEN - 1));
    assign relIdx  = 4'(bus.cpu_addr - START_W);

    always_comb begin
        oldWord = {20'd0, ctlDefault_q, ctlEnable_q};
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (relIdx == 4'(3 * r + 1)) oldWord = regStart_q[r];
            if (relIdx == 4'(3 * r + 2)) oldWord = regEnd_q[r];
            if (relIdx == 4'(3 * r + 3)) oldWord = {19'd0, regAttr_q[r]};
        end
    end
`endif

    // Table fields are at most 22 bits wide, so only the low bytes are merged.
    always_comb begin
        tblWrEn   = 1'b0;
        tblWrIdx  = 4'(loadIdx_q - 5'd1);
        tblWrData = bus.mem_rdata[21:0];
        if ((state_q == LOAD) && (loadIdx_q != 5'd0)) begin
            tblWrEn = 1'b1;
        end
`ifdef MPU_RELOAD_EN
        else if (accept && (bus.cpu_wstrb != 4'd0) && inTable) begin
            tblWrEn          = 1'b1;
            tblWrIdx         = relIdx;
            tblWrData[7:0]   = bus.cpu_wstrb[0] ? bus.cpu_wdata[7:0]   : oldWord[7:0];
            tblWrData[15:8]  = bus.cpu_wstrb[1] ? bus.cpu_wdata[15:8]  : oldWord[15:8];
            tblWrData[21:16] = bus.cpu_wstrb[2] ? bus.cpu_wdata[21:16] : oldWord[21:16];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            loadIdx_q    <= 5'd0;
            memAddr_q    <= 22'd0;
            memWdata_q   <= '0;
            faultPc_q    <= 32'd0;
            ctlEnable_q  <= 1'b0;
            ctlDefault_q <= 1'b0;
            for (int r = 0; r < NUM_REGIONS; r++) begin
                regStart_q[r] <= 22'd0;
                regEnd_q[r]   <= 22'd0;
                regAttr_q[r]  <= 3'd0;
            end
        end else begin
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            if (tblWrEn) begin
                if (tblWrIdx == 4'd0) begin
                    ctlEnable_q  <= tblWrData[0];
                    ctlDefault_q <= tblWrData[1];
                end
                for (int r = 0; r < NUM_REGIONS; r++) begin
                    if (tblWrIdx == 4'(3 * r + 1)) regStart_q[r] <= tblWrData;
                    if (tblWrIdx == 4'(3 * r + 2)) regEnd_q[r]   <= tblWrData;
                    if (tblWrIdx == 4'(3 * r + 3)) regAttr_q[r]  <= tblWrData[2:0];
                end
            end
            case (state_q)
                LOAD: begin
                    if (loadIdx_q == 5'(MPU_LEN))
                        state_q <= IDLE;
                    else
                        loadIdx_q <= loadIdx_q + 5'd1;
                end
                IDLE: begin
                    if (accept) begin
                        state_q <= ACCESS;
                    end else if (deny) begin
                        state_q   <= FAULT;
                        faultPc_q <= pc_addr;
                    end
                end
                ACCESS:  state_q <= IDLE;
                FAULT:   state_q <= IDLE;
                default: state_q <= LOAD;
            endcase
        end
    end

    // The load address is combinational from the index, so reset gates it to 0.
    assign bus.mem_addr    = reset ? 22'd0 : memAddr_d;
    assign bus.mem_wdata   = memWdata_d;
    assign bus.mem_wen     = accept ? bus.cpu_wstrb : 4'd0;
    assign bus.cpu_ready   = (state_q == ACCESS) || (state_q == FAULT);
    assign bus.cpu_rdata   = (state_q == ACCESS) ? bus.mem_rdata : '0;
    assign interrupt       = (state_q == FAULT);
    assign inform_cpu_wait = (state_q == LOAD);
    assign fault_pc        = faultPc_q;
endmodule

// File: tb/tb_mem_access_guard.sv
// Directed bench for mem_access_guard: table-driven access vectors plus
// hand-written reset, default-allow and table-reload sequences.
module tb_mem_access_guard;
    typedef struct {
        logic        isInst;
        logic [21:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        allowed;
        logic        chkData;
        logic [31:0] rdata;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        is_inst;
    logic [31:0] pc_addr;
    logic        inform_cpu_wait;
    logic        interrupt;
    logic [31:0] fault_pc;
    logic [31:0] sram [0:1023];
    int          checks;
    int          errors;
    vec_t        vecs [14];

    mem_access_guard_if #(.DATA_WIDTH(32)) bus ();

    mem_access_guard #(
        .DATA_WIDTH(32),
        .MPU_START_ADDR(768),
        .MPU_LEN(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .is_inst(is_inst),
        .pc_addr(pc_addr),
        .inform_cpu_wait(inform_cpu_wait),
        .interrupt(interrupt),
        .fault_pc(fault_pc),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous word SRAM with byte write enables and one-cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_wen[b]) sram[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        bus.mem_rdata <= sram[bus.mem_addr[9:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a quiet point in IDLE; returns one cycle after the ready cycle.
    task automatic applyStimulus(input vec_t v);
        is_inst       = v.isInst;
        bus.cpu_addr  = v.addr;
        bus.cpu_wstrb = v.wstrb;
        bus.cpu_wdata = v.wdata;
        pc_addr       = v.pc;
        bus.cpu_valid = 1'b1;
        #1;
        checkOutput("req_wen", 32'(bus.mem_wen), v.allowed ? 32'(v.wstrb) : 32'd0);
        if (v.allowed) begin
            checkOutput("req_addr", 32'(bus.mem_addr), 32'(v.addr));
            if (v.wstrb != 4'd0) checkOutput("req_wdata", bus.mem_wdata, v.wdata);
        end
        @(posedge clk); #1;
        checkOutput("ready", 32'(bus.cpu_ready), 32'd1);
        checkOutput("irq", 32'(interrupt), v.allowed ? 32'd0 : 32'd1);
        checkOutput("ready_wen", 32'(bus.mem_wen), 32'd0);
        if (!v.allowed) begin
            checkOutput("fault_rdata", bus.cpu_rdata, 32'd0);
            checkOutput("fault_pc", fault_pc, v.pc);
        end else if (v.chkData) begin
            checkOutput("rdata", bus.cpu_rdata, v.rdata);
        end
        bus.cpu_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_low", 32'(bus.cpu_ready), 32'd0);
        checkOutput("irq_low", 32'(interrupt), 32'd0);
    endtask

    task automatic waitLoad();
        int n = 0;
        while (inform_cpu_wait && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("load_done", 32'(inform_cpu_wait), 32'd0);
        checkOutput("load_cycles", 32'(n), 32'd17);
    endtask

    function automatic vec_t mk(input logic isInst, input logic [21:0] addr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, input logic [31:0] pc, input logic allowed,
                                input logic chkData, input logic [31:0] rdata);
        vec_t v;
        v.isInst = isInst; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata;
        v.pc = pc; v.allowed = allowed; v.chkData = chkData; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        logic [31:0] tbl [16];
        checks = 0;
        errors = 0;
        tbl = '{32'h1, 32'h0, 32'hFF, 32'h7, 32'h200, 32'h2FF, 32'h5, 32'h100, 32'h1FF, 32'h0,
                32'h80, 32'h90, 32'h0, 32'h3A0, 32'h39F, 32'h7};
        for (int i = 0; i < 1024; i++) sram[i] = 32'hA500_0000 | i;
        for (int i = 0; i < 16; i++) sram[768 + i] = tbl[i];

        vecs[0]  = mk(1'b1, 22'h010, 4'h0, 32'h0,         32'h0,   1'b1, 1'b1, 32'hA500_0010);
        vecs[1]  = mk(1'b0, 22'h100, 4'h0, 32'h0,         32'h400, 1'b0, 1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 22'h200, 4'hF, 32'hDEADBEEF,  32'h404, 1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 22'h200, 4'h0, 32'h0,         32'h0,   1'b1, 1'b1, 32'hA500_0200);
        vecs[4]  = mk(1'b1, 22'h2FF, 4'h0, 32'h0,         32'h0,   1'b1, 1'b1, 32'hA500_02FF);
        vecs[5]  = mk(1'b0, 22'h0FF, 4'h0, 32'h0,         32'h0,   1'b1, 1'b1, 32'hA500_00FF);
        vecs[6]  = mk(1'b0, 22'h085, 4'h0, 32'h0,         32'h0,   1'b1, 1'b1, 32'hA500_0085);
        vecs[7]  = mk(1'b0, 22'h3A0, 4'h0, 32'h0,         32'h408, 1'b0, 1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 22'h000, 4'h3, 32'h1234_5678, 32'h0,   1'b1, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 22'h000, 4'h0, 32'h0,         32'h0,   1'b1, 1'b1, 32'hA500_5678);
        vecs[10] = mk(1'b1, 22'h100, 4'h0, 32'h0,         32'h40C, 1'b0, 1'b0, 32'h0);
        vecs[11] = mk(1'b0, 22'h1FF, 4'h0, 32'h0,         32'h410, 1'b0, 1'b0, 32'h0);
        vecs[12] = mk(1'b0, 22'h300, 4'h0, 32'h0,         32'h414, 1'b0, 1'b0, 32'h0);
        vecs[13] = mk(1'b1, 22'h080, 4'h0, 32'h0,         32'h0,   1'b1, 1'b1, 32'hA500_0080);

        reset = 1'b1; is_inst = 1'b0; pc_addr = 32'd0;
        bus.cpu_valid = 1'b0; bus.cpu_addr = 22'd0; bus.cpu_wdata = 32'd0; bus.cpu_wstrb = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wait", 32'(inform_cpu_wait), 32'd1);
        checkOutput("rst_ready", 32'(bus.cpu_ready), 32'd0);
        checkOutput("rst_rdata", bus.cpu_rdata, 32'd0);
        checkOutput("rst_irq", 32'(interrupt), 32'd0);
        checkOutput("rst_wen", 32'(bus.mem_wen), 32'd0);
        checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_wdata", bus.mem_wdata, 32'd0);
        checkOutput("rst_fault_pc", fault_pc, 32'd0);

        // Load sequence: 16 addresses from 768, then one capture cycle.
        reset = 1'b0;
        bus.cpu_valid = 1'b1;
        #1;
        for (int k = 0; k < 17; k++) begin
            checkOutput("load_wait", 32'(inform_cpu_wait), 32'd1);
            checkOutput("load_ready", 32'(bus.cpu_ready), 32'd0);
            if (k < 16) begin
                checkOutput("load_addr", 32'(bus.mem_addr), 32'(768 + k));
                checkOutput("load_wen", 32'(bus.mem_wen), 32'd0);
            end
            @(posedge clk); #1;
        end
        bus.cpu_valid = 1'b0;
        checkOutput("load_end", 32'(inform_cpu_wait), 32'd0);

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        // Reset while a permitted fetch is in its ready cycle.
        is_inst = 1'b1; bus.cpu_addr = 22'h010; bus.cpu_wstrb = 4'h0; bus.cpu_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_ready", 32'(bus.cpu_ready), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_ready", 32'(bus.cpu_ready), 32'd0);
        checkOutput("abort_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("abort_wait", 32'(inform_cpu_wait), 32'd1);
        bus.cpu_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("restart_addr", 32'(bus.mem_addr), 32'd768);
        waitLoad();
        applyStimulus(mk(1'b0, 22'h3A0, 4'h0, 32'h0, 32'h500, 1'b0, 1'b0, 32'h0));

        // Control word 0x3: unmatched addresses become allowed, regions still apply.
        sram[768] = 32'h3;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        waitLoad();
        applyStimulus(mk(1'b0, 22'h3A0, 4'h0, 32'h0, 32'h0,   1'b1, 1'b1, 32'hA500_03A0));
        applyStimulus(mk(1'b0, 22'h100, 4'h0, 32'h0, 32'h504, 1'b0, 1'b0, 32'h0));

        // Store zero over the control word, then retry the protected region.
        applyStimulus(mk(1'b0, 22'h300, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
        checkOutput("sram_ctl", sram[768], 32'h0);
`ifdef MPU_RELOAD_EN
        applyStimulus(mk(1'b0, 22'h100, 4'h0, 32'h0, 32'h0,   1'b1, 1'b1, 32'hA500_0100));
`else
        applyStimulus(mk(1'b0, 22'h100, 4'h0, 32'h0, 32'h508, 1'b0, 1'b0, 32'h0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
